// File: rtl/vram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_pkg                                                           |
// | Shared framebuffer geometry, VRAM word packing and fill states.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vram_pkg;

   localparam int FB_WIDTH_DEF  = 480;
   localparam int FB_HEIGHT_DEF = 136;
   localparam int VRAM_ADDR_W   = 16;
   localparam int VRAM_DATA_W   = 16;
   localparam int COLOR_W       = 12;
   localparam int CMD_W         = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_FILL  = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_t;

   // 12-bit {B,G,R} colour placed in the low bits of a VRAM word
   function automatic logic [VRAM_DATA_W-1:0] pack_pixel(input logic [COLOR_W-1:0] color);
      return {4'h0, color};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vram_fill.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_fill                                                          |
// | Rectangle-fill engine: one VRAM word write per clock, row-major.   |
// | Define VRAM_FILL_CLIP_EN to clip rectangles instead of rejecting.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vram_fill
   import vram_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [CMD_W-1:0]       cmd_x,
   input  logic [CMD_W-1:0]       cmd_y,
   input  logic [CMD_W-1:0]       cmd_w,
   input  logic [CMD_W-1:0]       cmd_h,
   input  logic [COLOR_W-1:0]     cmd_color,
   output logic [VRAM_ADDR_W-1:0] vram_write_addr,
   output logic [VRAM_DATA_W-1:0] vram_write_data,
   output logic                   vram_write_en,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam logic [CMD_W:0]         c_fb_w   = (CMD_W+1)'(FB_WIDTH);
   localparam logic [CMD_W:0]         c_fb_h   = (CMD_W+1)'(FB_HEIGHT);
   localparam logic [VRAM_ADDR_W-1:0] c_stride = VRAM_ADDR_W'(FB_WIDTH);

   fill_state_t            state_q, state_d;
   logic [CMD_W-1:0]       x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
   logic [COLOR_W-1:0]     color_q, color_d;
   logic [CMD_W:0]         x_end_q, x_end_d, y_end_q, y_end_d;
   logic [CMD_W-1:0]       x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
   logic [VRAM_ADDR_W-1:0] row_base_q, row_base_d;
   logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [VRAM_DATA_W-1:0] data_q, data_d;
   logic                   we_q, we_d;
   logic                   err_q, err_d;

   logic [CMD_W:0]         sum_x, sum_y, x_end_c, y_end_c;
   logic                   empty_c, bad_c, x_last, y_last;
   logic [VRAM_ADDR_W-1:0] row_base_c;

   // Bounds for the latched command; only meaningful in SETUP
   always_comb begin
      sum_x      = {1'b0, x0_q} + {1'b0, w_q};
      sum_y      = {1'b0, y0_q} + {1'b0, h_q};
      row_base_c = VRAM_ADDR_W'(y0_q) * c_stride;
`ifdef VRAM_FILL_CLIP_EN
      x_end_c = (sum_x > c_fb_w) ? c_fb_w : sum_x;
      y_end_c = (sum_y > c_fb_h) ? c_fb_h : sum_y;
      bad_c   = 1'b0;
      empty_c = ({1'b0, x0_q} >= c_fb_w) || ({1'b0, y0_q} >= c_fb_h) ||
                (x_end_c <= {1'b0, x0_q}) || (y_end_c <= {1'b0, y0_q});
`else
      x_end_c = sum_x;
      y_end_c = sum_y;
      bad_c   = (sum_x > c_fb_w) || (sum_y > c_fb_h);
      empty_c = bad_c || (w_q == '0) || (h_q == '0);
`endif
   end

   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      w_d        = w_q;
      h_d        = h_q;
      color_d    = color_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      x_cnt_d    = x_cnt_q;
      y_cnt_d    = y_cnt_q;
      row_base_d = row_base_q;
      addr_d     = addr_q;
      data_d     = data_q;
      we_d       = 1'b0;
      err_d      = 1'b0;
      x_last     = (({1'b0, x_cnt_q} + 11'd1) == x_end_q);
      y_last     = (({1'b0, y_cnt_q} + 11'd1) == y_end_q);

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               x0_d    = cmd_x;
               y0_d    = cmd_y;
               w_d     = cmd_w;
               h_d     = cmd_h;
               color_d = cmd_color;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            x_end_d    = x_end_c;
            y_end_d    = y_end_c;
            x_cnt_d    = x0_q;
            y_cnt_d    = y0_q;
            row_base_d = row_base_c;
            data_d     = pack_pixel(color_q);
            if (empty_c) begin
               err_d   = bad_c;
               state_d = ST_DONE;
            end else begin
               // Counters track the pixel being presented on the write port
               we_d    = 1'b1;
               addr_d  = row_base_c + VRAM_ADDR_W'(x0_q);
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (x_last && y_last) begin
               state_d = ST_DONE;
            end else if (x_last) begin
               x_cnt_d    = x0_q;
               y_cnt_d    = y_cnt_q + 10'd1;
               row_base_d = row_base_q + c_stride;
               addr_d     = row_base_q + c_stride + VRAM_ADDR_W'(x0_q);
               we_d       = 1'b1;
            end else begin
               x_cnt_d = x_cnt_q + 10'd1;
               addr_d  = row_base_q + VRAM_ADDR_W'(x_cnt_q) + 16'd1;
               we_d    = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         color_q    <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         w_q        <= w_d;
         h_q        <= h_d;
         color_q    <= color_d;
         x_end_q    <= x_end_d;
         y_end_q    <= y_end_d;
         x_cnt_q    <= x_cnt_d;
         y_cnt_q    <= y_cnt_d;
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         we_q       <= we_d;
         err_q      <= err_d;
      end
   end

   assign cmd_ready       = (state_q == ST_IDLE);
   assign busy            = (state_q == ST_SETUP) || (state_q == ST_FILL);
   assign done            = (state_q == ST_DONE);
   assign err             = err_q;
   assign vram_write_addr = addr_q;
   assign vram_write_data = data_q;
   assign vram_write_en   = we_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_fill.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vram_fill                                                       |
// | Randomised and directed self-checking bench for vram_fill.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_vram_fill;

   localparam int FBW = 480;
   localparam int FBH = 136;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
   logic [11:0] cmd_color = '0;
   logic        cmd_ready, vram_write_en, busy, done, err;
   logic [15:0] vram_write_addr, vram_write_data;

   vram_fill #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
      .vram_write_addr(vram_write_addr), .vram_write_data(vram_write_data),
      .vram_write_en(vram_write_en), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [15:0] obs_addr[$];
   logic [15:0] obs_data[$];
   int          obs_rel[$];
   int          exp_addr[$];
   bit          exp_err;
   int          first_rel, done_rel, proto_bad;
   bit          err_seen, ready_after;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected write list straight from the rectangle geometry
   task automatic model(input int x, input int y, input int w, input int h);
      int xe, ye;
      exp_addr.delete();
      exp_err = 1'b0;
      xe = x + w;
      ye = y + h;
`ifdef VRAM_FILL_CLIP_EN
      if (xe > FBW) xe = FBW;
      if (ye > FBH) ye = FBH;
`else
      if (xe > FBW || ye > FBH) begin
         exp_err = 1'b1;
         xe = x;
         ye = y;
      end
`endif
      for (int yy = y; yy < ye; yy++)
         for (int xx = x; xx < xe; xx++)
            exp_addr.push_back(yy * FBW + xx);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) step();
   endtask

   // Issue one command and record what the write port does, relative to the handshake cycle
   task automatic do_cmd(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                         input logic [9:0] h, input logic [11:0] c);
      int rel;
      obs_addr.delete(); obs_data.delete(); obs_rel.delete();
      first_rel = -1; done_rel = -1; proto_bad = 0; err_seen = 0; ready_after = 0;
      wait_ready();
      cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      rel = 1;
      while (rel < 60 && done_rel < 0) begin
         if (vram_write_en === 1'b1) begin
            obs_addr.push_back(vram_write_addr);
            obs_data.push_back(vram_write_data);
            if (first_rel < 0) first_rel = rel;
         end
         if (done === 1'b1) begin
            done_rel = rel;
            err_seen = err;
            if (busy !== 1'b0) proto_bad++;
         end else begin
            if (busy !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b0) proto_bad++;
            step();
            rel++;
         end
      end
      if (done_rel >= 0) begin
         step();
         ready_after = cmd_ready;
         if (done !== 1'b0 || err !== 1'b0 || vram_write_en !== 1'b0) proto_bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b1;
      cmd_x = 10'd1; cmd_y = 10'd1; cmd_w = 10'd2; cmd_h = 10'd2; cmd_color = 12'hFFF;
      step(); step(); step();
      reset = 1'b0;
      cmd_valid = 1'b0;
      total++;
      if (vram_write_en !== 1'b0 || vram_write_addr !== 16'h0 || vram_write_data !== 16'h0) begin
         bad++;
         $display("FAIL reset_write_port: en=%b addr=%h data=%h want 0/0000/0000",
                  vram_write_en, vram_write_addr, vram_write_data);
      end
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_status: busy=%b done=%b err=%b ready=%b want 0/0/0/1",
                  busy, done, err, cmd_ready);
      end
      step();
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_drops_cmd: busy=%b ready=%b want 0/1", busy, cmd_ready);
      end
   endtask

   task automatic test_fill_cases();
      int dx[5] = '{0, 0, 478, 479, 100};
      int dy[5] = '{0, 0, 0, 135, 50};
      int dw[5] = '{2, 0, 4, 1, 3};
      int dh[5] = '{2, 5, 1, 1, 2};
      int dc[5] = '{'h0F0, 'h123, 'h00F, 'hABC, 'h5A5};
      int x, y, w, h, c, n;
      logic [15:0] ed;
      for (int k = 0; k < 14; k++) begin
         if (k < 5) begin
            x = dx[k]; y = dy[k]; w = dw[k]; h = dh[k]; c = dc[k];
         end else begin
            x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(FBW - 6, FBW + 1))
                                            : int'($urandom_range(0, FBW - 1));
            y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(FBH - 4, FBH + 1))
                                            : int'($urandom_range(0, FBH - 1));
            w = $urandom_range(0, 6);
            h = $urandom_range(0, 4);
            c = $urandom_range(0, 4095);
         end
         model(x, y, w, h);
         n = exp_addr.size();
         ed = {4'h0, 12'(c)};
         do_cmd(10'(x), 10'(y), 10'(w), 10'(h), 12'(c));
         total++;
         if (done_rel != 2 + n) begin
            bad++;
            $display("FAIL done_cycle case%0d: got T+%0d want T+%0d", k, done_rel, 2 + n);
         end
         total++;
         if (err_seen !== exp_err) begin
            bad++;
            $display("FAIL err_flag case%0d: got %b want %b", k, err_seen, exp_err);
         end
         total++;
         if (obs_addr.size() != n) begin
            bad++;
            $display("FAIL write_count case%0d: got %0d want %0d", k, obs_addr.size(), n);
         end
         for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            total++;
            if (obs_addr[i] !== 16'(exp_addr[i]) || obs_data[i] !== ed) begin
               bad++;
               $display("FAIL write case%0d[%0d]: got %h/%h want %h/%h",
                        k, i, obs_addr[i], obs_data[i], 16'(exp_addr[i]), ed);
            end
         end
         if (n > 0) begin
            total++;
            if (first_rel != 2) begin
               bad++;
               $display("FAIL first_write case%0d: got T+%0d want T+2", k, first_rel);
            end
         end
         total++;
         if (proto_bad != 0 || ready_after !== 1'b1) begin
            bad++;
            $display("FAIL protocol case%0d: bad_cycles=%0d ready_after=%b want 0/1",
                     k, proto_bad, ready_after);
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      int seen, dones;
      seen = 0;
      wait_ready();
      cmd_x = 10'd10; cmd_y = 10'd5; cmd_w = 10'd3; cmd_h = 10'd3; cmd_color = 12'h5A5;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         if (vram_write_en === 1'b1) seen++;
         if (seen < 3) step();
      end
      total++;
      if (seen != 3 || vram_write_addr !== 16'(5 * FBW + 12)) begin
         bad++;
         $display("FAIL mid_fill_third_write: writes=%0d addr=%h want 3/%h",
                  seen, vram_write_addr, 16'(5 * FBW + 12));
      end
      reset = 1'b1;
      step();
      total++;
      if (vram_write_en !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL mid_fill_reset: en=%b done=%b want 0/0", vram_write_en, done);
      end
      reset = 1'b0;
      step();
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || vram_write_en !== 1'b0) begin
         bad++;
         $display("FAIL mid_fill_idle: ready=%b busy=%b en=%b want 1/0/0",
                  cmd_ready, busy, vram_write_en);
      end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1 || vram_write_en === 1'b1) dones++;
         step();
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL mid_fill_quiet: activity_cycles=%0d want 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      int ea[$];
      logic [15:0] ed[$];
      int na, nb, rel, da, db, rb, er;
      model(20, 10, 2, 2);
      ea = exp_addr;
      na = ea.size();
      for (int i = 0; i < na; i++) ed.push_back(16'h0C3A);
      model(30, 11, 3, 1);
      nb = exp_addr.size();
      for (int i = 0; i < nb; i++) begin
         ea.push_back(exp_addr[i]);
         ed.push_back(16'h0B17);
      end
      obs_addr.delete(); obs_data.delete(); obs_rel.delete();
      wait_ready();
      cmd_x = 10'd20; cmd_y = 10'd10; cmd_w = 10'd2; cmd_h = 10'd2; cmd_color = 12'hC3A;
      cmd_valid = 1'b1;
      step();
      cmd_x = 10'd30; cmd_y = 10'd11; cmd_w = 10'd3; cmd_h = 10'd1; cmd_color = 12'hB17;
      rel = 1; da = -1; db = -1; rb = -1;
      while (rel < 60 && db < 0) begin
         if (vram_write_en === 1'b1) begin
            obs_addr.push_back(vram_write_addr);
            obs_data.push_back(vram_write_data);
            obs_rel.push_back(rel);
         end
         if (da >= 0 && rb < 0 && rel > da && cmd_ready === 1'b1) rb = rel;
         if (done === 1'b1) begin
            if (da < 0) da = rel;
            else begin
               db = rel;
               cmd_valid = 1'b0;
            end
         end
         if (db < 0) begin
            step();
            rel++;
         end
      end
      cmd_valid = 1'b0;
      total++;
      if (da != 2 + na || rb != 3 + na || db != 5 + na + nb) begin
         bad++;
         $display("FAIL b2b_timing: done_a=%0d ready=%0d done_b=%0d want %0d/%0d/%0d",
                  da, rb, db, 2 + na, 3 + na, 5 + na + nb);
      end
      total++;
      if (obs_addr.size() != na + nb) begin
         bad++;
         $display("FAIL b2b_count: got %0d want %0d", obs_addr.size(), na + nb);
      end
      for (int i = 0; i < na + nb && i < obs_addr.size(); i++) begin
         er = (i < na) ? 2 + i : 5 + na + (i - na);
         total++;
         if (obs_addr[i] !== 16'(ea[i]) || obs_data[i] !== ed[i] || obs_rel[i] != er) begin
            bad++;
            $display("FAIL b2b_write[%0d]: got %h/%h@T+%0d want %h/%h@T+%0d",
                     i, obs_addr[i], obs_data[i], obs_rel[i], 16'(ea[i]), ed[i], er);
         end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_fill_cases();
      test_reset_mid_fill();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/vram_fill.md
# vram_fill

Rectangle-fill engine on the VRAM write port: accepts one rectangle command (origin, size, colour) through a valid/ready handshake and emits one VRAM word write per clock, row-major, until the rectangle is painted. Drives `vram_write_addr` / `vram_write_data` / `vram_write_en` of the VGA driver, which scans the same VRAM out to the display. Lets the CPU clear screens and draw boxes without per-pixel stores.

## Interface
- `FB_WIDTH`, default 480: pixels per row; also the row stride in VRAM words.
- `FB_HEIGHT`, default 136: rows. `FB_WIDTH*FB_HEIGHT` must be ≤ 65536.
- `clk` input, 1 bit: sole clock.
- `reset` input, 1 bit: synchronous, active-high.
- `cmd_valid` input, 1 bit: command present.
- `cmd_ready` output, 1 bit: engine idle, command accepted when both are high.
- `cmd_x` input, 10 bits: left column.
- `cmd_y` input, 10 bits: top row.
- `cmd_w` input, 10 bits: width in pixels.
- `cmd_h` input, 10 bits: height in rows.
- `cmd_color` input, 12 bits: {B[11:8], G[7:4], R[3:0]}.
- `vram_write_addr` output, 16 bits: word address, `y*FB_WIDTH + x`.
- `vram_write_data` output, 16 bits: `{4'h0, cmd_color}`.
- `vram_write_en` output, 1 bit: write strobe, one pixel per cycle.
- `busy` output, 1 bit: high in SETUP and FILL.
- `done` output, 1 bit: one-cycle pulse at command completion.
- `err` output, 1 bit: one-cycle pulse on rejected command (only without clipping).

## Operation
- States: IDLE → SETUP → FILL → DONE → IDLE.
- IDLE: `cmd_ready`=1; on handshake, latch all cmd fields, go SETUP.
- SETUP: compute clipped/validated bounds; register `row_base = y*FB_WIDTH` (single multiply, only here); `x_cnt`=x0, `y_cnt`=y0. Empty rectangle → DONE; else FILL.
- FILL: each cycle assert `vram_write_en` with addr `row_base + x_cnt`. `x_cnt` increments; at `x_end-1`, `x_cnt`←x0, `y_cnt`++, `row_base += FB_WIDTH`. Write at (`x_end-1`, `y_end-1`) is the last; then DONE.
- DONE: `done`=1 for one cycle; `cmd_ready` held low; next state IDLE.
- Bounds arithmetic in 11 bits: `x_end = x0 + w`, `y_end = y0 + h` (no overflow possible with 10-bit inputs).
- Empty rectangle: `w==0` or `h==0` (after clipping) → no writes, `done` still pulses.
- Address never exceeds `FB_WIDTH*FB_HEIGHT-1`; `row_base` is 16 bits, no wrap.
- Command fields ignored while not in IDLE; `cmd_valid` may stay high, it does not queue.

## Timing
- Handshake at cycle T (IDLE); SETUP at T+1; first write at T+2; last write at T+1+W*H (W, H after clipping); `done` at T+2+W*H; `cmd_ready`=1 again at T+3+W*H.
- Empty rectangle: `done` at T+2.
- Write outputs are registered; addr/data/en change together on `clk`.
- Reset values: `vram_write_en`=0, `vram_write_addr`=0, `vram_write_data`=0, `busy`=0, `done`=0, `err`=0, state IDLE, so `cmd_ready`=1 from the first cycle after the reset edge.
- Reset mid-FILL: no write in the cycle after the reset edge; no `done`; partial rectangle stays in VRAM.
- Reset together with handshake: reset wins, command dropped.

## Configuration
- `VRAM_FILL_CLIP_EN` defined: bounds clipped in SETUP: `x_end = min(x0+w, FB_WIDTH)`, `y_end = min(y0+h, FB_HEIGHT)`; `x0 ≥ FB_WIDTH` or `y0 ≥ FB_HEIGHT` → empty rectangle. `err` tied 0.
- Undefined: SETUP checks `x0+w > FB_WIDTH` or `y0+h > FB_HEIGHT`; violation → no writes, `err` pulses in the DONE cycle together with `done`. No clipping logic is synthesized.

## Structure
- Package `vram_pkg`: default `FB_WIDTH`/`FB_HEIGHT`, VRAM address/data widths, pixel packing function (12-bit colour → 16-bit word), state enum `fill_state_t`.
- No sub-module; clip/validate logic is a few comparators inline in SETUP.

## Test plan
- x=0,y=0,w=2,h=2,color=0x0F0 → writes addr 0,1,480,481 data 0x00F0 at T+2..T+5; `done` at T+6; `busy` high T+1..T+5.
- w=0, h=5 → no `vram_write_en`; `done` at T+2; `cmd_ready` at T+3.
- x=478,y=0,w=4,h=1: with `VRAM_FILL_CLIP_EN` → writes 478,479 only, `done` at T+4; without → no writes, `err`+`done` at T+2.
- x=479,y=135,w=1,h=1 → single write addr 65279, data per colour.
- 3×3 fill, `reset` asserted during 3rd write → `vram_write_en`=0 next cycle, no `done`, `cmd_ready`=1 after reset released.
- `cmd_valid` held high with two back-to-back commands → second accepted at the first `cmd_ready` cycle after the first `done`; its first write two cycles later; no overlap of writes.
